chroma_calib_ctrl: RTL and testbench
====================================

# chroma_calib_ctrl

Calibration controller for the chroma-key threshold stage. On a user request it waits for a frame boundary and accumulates the HSV values of pixels inside a fixed screen box over 2^FRAMES_LOG2 frames. It then computes the per-channel mean and drives it, with a one-cycle load strobe, onto the nominal H/S/V (and optionally range) settings of the chroma-key matcher. It sits between the HSV conversion pipeline and the chroma-key stage, in parallel with the button-driven manual adjust path.

## Interface
- BOX_X, 504: left column of sample box (hcount units)
- BOX_Y, 376: top row of sample box (vcount units)
- BOX_LOG2_W, 4: box width = 2^BOX_LOG2_W pixels
- BOX_LOG2_H, 4: box height = 2^BOX_LOG2_H lines
- FRAMES_LOG2, 2: frames averaged = 2^FRAMES_LOG2
- H_DEFAULT, 85 / S_DEFAULT, 94 / V_DEFAULT, 202: reset values of nominal outputs
- RANGE_DEFAULT, 50: reset/fixed value of range_out
- RANGE_MARGIN, 8: margin added to measured half-spread (spread feature only)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- vsync  in  1  vertical sync, frame boundary = falling edge
- hcount  in  11  pixel column of hsv_in
- vcount  in  10  pixel row of hsv_in
- hsv_in  in  24  {H[23:16], S[15:8], V[7:0]}, aligned with hcount/vcount
- cal_start  in  1  single-cycle request pulse (debounced upstream)
- h_nom, s_nom, v_nom  out  8 each  calibrated nominal values, registered
- range_out  out  8  calibrated H/S range, registered
- cal_load  out  1  one-cycle strobe: outputs just updated
- busy  out  1  high whenever state != IDLE

## Operation
- vsync_fall = (vsync == 0) && (vsync_q == 1); vsync_q is vsync registered on clk.
- in_box = hcount in [BOX_X, BOX_X+2^BOX_LOG2_W) and vcount in [BOX_Y, BOX_Y+2^BOX_LOG2_H).
- States: IDLE, ARM, ACCUM, LOAD.
  - IDLE: cal_start -> ARM. Otherwise hold.
  - ARM: wait for vsync_fall -> ACCUM; clear accumulators and frame_cnt on the same edge.
  - ACCUM: each clk with in_box adds H, S, V to three accumulators of width 8+BOX_LOG2_W+BOX_LOG2_H+FRAMES_LOG2 (18 at defaults), so overflow is impossible. On vsync_fall: if frame_cnt == 2^FRAMES_LOG2-1, go to LOAD and register h/s/v_nom = acc >> (BOX_LOG2_W+BOX_LOG2_H+FRAMES_LOG2) (floor); else increment frame_cnt.
  - LOAD: cal_load = 1 for exactly this cycle, then IDLE.
- cal_start while busy is ignored; it neither restarts nor queues.
- Outputs hold their last calibration indefinitely; manual adjust downstream may override them after cal_load.
- Reset (any state, any time): state IDLE; h_nom=H_DEFAULT, s_nom=S_DEFAULT, v_nom=V_DEFAULT, range_out=RANGE_DEFAULT; cal_load=0, busy=0; accumulators, frame_cnt and vsync_q are cleared. A run interrupted by reset produces no cal_load.

## Timing
- Sampling: the pixel presented in cycle t is added at the clk edge ending t; there is no input pipeline.
- Total samples = 2^(BOX_LOG2_W+BOX_LOG2_H+FRAMES_LOG2), 1024 at defaults.
- The final vsync_fall is detected in cycle T. Outputs are updated at the end of T. cal_load and the new values are both visible in cycle T+1. busy falls in cycle T+2.
- A vsync_fall in the same cycle as cal_start in IDLE is not used. Accumulation starts at the next fall.

## Configuration
- CHROMA_CAL_SPREAD_EN defined: during ACCUM, track min and max of sampled H, both cleared on ARM->ACCUM. At LOAD, range_out = ((h_max - h_min) >> 1) + RANGE_MARGIN, saturating at 255, registered alongside h/s/v_nom.
- Undefined: no min/max logic; range_out is constant RANGE_DEFAULT.

## Test plan
- Constant hsv_in = (100,120,180) inside the box, (0,0,0) outside, then pulse cal_start -> after 4 full frames, cal_load high exactly 1 cycle; h/s/v_nom = 100/120/180; busy low 2 cycles after the final vsync fall.
- Box H = 90 on even frames and 110 on odd frames -> h_nom = 100.
- Box H = hcount-BOX_X (0..15 ramp) -> h_nom = 7 (floor of 7.5).
- Reset asserted mid-ACCUM (frame 2) -> outputs read 85/94/202/50 immediately; busy = 0; no cal_load ever pulses for that run.
- Second cal_start during ACCUM -> ignored; cal_load occurs at the same cycle as it would with a single start.
- Spread: box H ranging 80..120. With CHROMA_CAL_SPREAD_EN, range_out = 28. Without the macro, range_out = 50.

Source files
------------

// File: rtl/chroma_calib_ctrl.sv
// chroma_calib_ctrl: averages box HSV over 2^FRAMES_LOG2 frames into the chroma-key nominal settings.
// Optional macro CHROMA_CAL_SPREAD_EN also derives range_out from the sampled H spread.
module chroma_calib_ctrl #(
  parameter int BOX_X         = 504,
  parameter int BOX_Y         = 376,
  parameter int BOX_LOG2_W    = 4,
  parameter int BOX_LOG2_H    = 4,
  parameter int FRAMES_LOG2   = 2,
  parameter int H_DEFAULT     = 85,
  parameter int S_DEFAULT     = 94,
  parameter int V_DEFAULT     = 202,
  parameter int RANGE_DEFAULT = 50
`ifdef CHROMA_CAL_SPREAD_EN
  ,parameter int RANGE_MARGIN = 8
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [23:0] hsv_in,
  input  logic        cal_start,
  output logic [7:0]  h_nom,
  output logic [7:0]  s_nom,
  output logic [7:0]  v_nom,
  output logic [7:0]  range_out,
  output logic        cal_load,
  output logic        busy
);
  localparam int SH = BOX_LOG2_W + BOX_LOG2_H + FRAMES_LOG2;
  localparam int AW = 8 + SH;
  localparam int FW = FRAMES_LOG2 > 0 ? FRAMES_LOG2 : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'((1 << FRAMES_LOG2) - 1);
  localparam logic [11:0] X_LO = 12'(BOX_X);
  localparam logic [11:0] X_HI = 12'(BOX_X + (1 << BOX_LOG2_W));
  localparam logic [10:0] Y_LO = 11'(BOX_Y);
  localparam logic [10:0] Y_HI = 11'(BOX_Y + (1 << BOX_LOG2_H));
  typedef enum logic [1:0] {IDLE, ARM, ACCUM, LOAD} state_t;
  state_t state_q;
  logic vsync_q;
  logic [FW-1:0] frame_cnt_q;
  logic [AW-1:0] h_acc_q, s_acc_q, v_acc_q;
  logic vsync_fall, in_box;
  assign vsync_fall = !vsync && vsync_q;
  assign in_box = {1'b0, hcount} >= X_LO && {1'b0, hcount} < X_HI &&
                  {1'b0, vcount} >= Y_LO && {1'b0, vcount} < Y_HI;
  assign busy = state_q != IDLE;
`ifdef CHROMA_CAL_SPREAD_EN
  logic [7:0] h_min_q, h_max_q, h_half;
  logic [8:0] range_sum;
  assign h_half = (h_max_q - h_min_q) >> 1;
  assign range_sum = {1'b0, h_half} + 9'(RANGE_MARGIN);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      h_acc_q     <= '0;
      s_acc_q     <= '0;
      v_acc_q     <= '0;
      h_nom       <= 8'(H_DEFAULT);
      s_nom       <= 8'(S_DEFAULT);
      v_nom       <= 8'(V_DEFAULT);
      range_out   <= 8'(RANGE_DEFAULT);
      cal_load    <= 1'b0;
`ifdef CHROMA_CAL_SPREAD_EN
      h_min_q     <= 8'hff;
      h_max_q     <= 8'h00;
`endif
    end else begin
      vsync_q  <= vsync;
      cal_load <= 1'b0;
      case (state_q)
        IDLE: if (cal_start) state_q <= ARM;
        ARM: if (vsync_fall) begin
          state_q     <= ACCUM;
          frame_cnt_q <= '0;
          h_acc_q     <= '0;
          s_acc_q     <= '0;
          v_acc_q     <= '0;
`ifdef CHROMA_CAL_SPREAD_EN
          h_min_q     <= 8'hff;
          h_max_q     <= 8'h00;
`endif
        end
        ACCUM: if (vsync_fall) begin
          if (frame_cnt_q == LAST_FRAME) begin
            state_q  <= LOAD;
            cal_load <= 1'b1;
            h_nom    <= h_acc_q[AW-1:SH];
            s_nom    <= s_acc_q[AW-1:SH];
            v_nom    <= v_acc_q[AW-1:SH];
`ifdef CHROMA_CAL_SPREAD_EN
            range_out <= range_sum[8] ? 8'hff : range_sum[7:0];
`endif
          end else frame_cnt_q <= frame_cnt_q + 1'b1;
        end else if (in_box) begin
          h_acc_q <= h_acc_q + AW'(hsv_in[23:16]);
          s_acc_q <= s_acc_q + AW'(hsv_in[15:8]);
          v_acc_q <= v_acc_q + AW'(hsv_in[7:0]);
`ifdef CHROMA_CAL_SPREAD_EN
          h_min_q <= hsv_in[23:16] < h_min_q ? hsv_in[23:16] : h_min_q;
          h_max_q <= hsv_in[23:16] > h_max_q ? hsv_in[23:16] : h_max_q;
`endif
        end
        LOAD: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chroma_calib_ctrl.sv
// tb_chroma_calib_ctrl: directed frames over a reduced raster, checked each cycle against a sample-queue model.
module tb_chroma_calib_ctrl;
  localparam int BX = 504, BY = 376;
  logic clk = 0, rst = 1, vsync = 0, cal_start = 0;
  logic [10:0] hcount = 0;
  logic [9:0] vcount = 0;
  logic [23:0] hsv_in = 0;
  logic [7:0] h_nom, s_nom, v_nom, range_out;
  logic cal_load, busy;
  int checks = 0, errors = 0;
  int cyc = 0, fall_cyc = 0, load_cyc = -1, idle_cyc = -1, loads = 0, fidx = 0;

  chroma_calib_ctrl dut (.clk(clk), .rst(rst), .vsync(vsync), .hcount(hcount), .vcount(vcount),
    .hsv_in(hsv_in), .cal_start(cal_start), .h_nom(h_nom), .s_nom(s_nom), .v_nom(v_nom),
    .range_out(range_out), .cal_load(cal_load), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: collect every in-box sample of the run, average with plain division at the end.
  int stage, nfr, m_min, m_max;
  int e_h = 85, e_s = 94, e_v = 202, e_r = 50;
  bit e_load, pv, fall;
  int hq[$], sq[$], vq[$];
  task automatic finish_run();
    int sh = 0, ss = 0, sv = 0, d;
    m_min = 255; m_max = 0;
    foreach (hq[i]) begin
      sh += hq[i]; ss += sq[i]; sv += vq[i];
      if (hq[i] < m_min) m_min = hq[i];
      if (hq[i] > m_max) m_max = hq[i];
    end
    e_h = sh / hq.size(); e_s = ss / sq.size(); e_v = sv / vq.size();
`ifdef CHROMA_CAL_SPREAD_EN
    d = (m_max - m_min) / 2 + 8;
    e_r = d > 255 ? 255 : d;
`else
    d = 0;
    e_r = 50 + d;
`endif
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stage = 0; e_load = 0; pv = 0;
      e_h = 85; e_s = 94; e_v = 202; e_r = 50;
    end else begin
      fall = pv && !vsync;
      pv = vsync;
      e_load = 0;
      if (stage == 3) stage = 0;
      else if (stage == 0) begin
        if (cal_start) stage = 1;
      end else if (stage == 1) begin
        if (fall) begin
          stage = 2; nfr = 0;
          hq.delete(); sq.delete(); vq.delete();
        end
      end else if (fall) begin
        nfr++;
        if (nfr == 4) begin
          finish_run(); stage = 3; e_load = 1;
        end
      end else if (hcount >= BX && hcount < BX + 16 && vcount >= BY && vcount < BY + 16) begin
        hq.push_back(int'(hsv_in[23:16]));
        sq.push_back(int'(hsv_in[15:8]));
        vq.push_back(int'(hsv_in[7:0]));
      end
    end
  end

  bit pbusy = 0;
  always @(posedge clk) begin
    #1;
    chk("h_nom", h_nom, e_h);
    chk("s_nom", s_nom, e_s);
    chk("v_nom", v_nom, e_v);
    chk("range_out", range_out, e_r);
    chk("cal_load", cal_load, e_load);
    chk("busy", busy, stage != 0);
    if (cal_load) begin loads++; load_cyc = cyc; end
    if (pbusy && !busy) idle_cyc = cyc;
    pbusy = busy;
  end

  function automatic logic [23:0] pix(input int mode, input int x, input int y);
    int dx = x - BX, dy = y - BY;
    logic [7:0] h;
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return 24'h0;
    case (mode)
      0: h = 8'd100;
      1: h = fidx % 2 ? 8'd110 : 8'd90;
      2: h = 8'(dx);
      default: h = 8'(80 + (dx + dy) * 40 / 30);
    endcase
    return {h, 8'd120, 8'd180};
  endfunction

  task automatic frame(input int mode);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); vsync = 1; hcount = 0; vcount = 0; hsv_in = 0;
    end
    @(negedge clk); vsync = 0; fall_cyc = cyc;
    for (int y = BY - 2; y < BY + 18; y++)
      for (int x = BX - 4; x < BX + 20; x++) begin
        @(negedge clk); hcount = 11'(x); vcount = 10'(y); hsv_in = pix(mode, x, y);
      end
    fidx++;
  endtask

  task automatic pulse();
    @(negedge clk); cal_start = 1;
    @(negedge clk); cal_start = 0;
  endtask

  task automatic run(input string name, input int mode, input bit extra, input int exp_h);
    int l0 = loads;
    pulse();
    for (int f = 0; f < 5; f++) begin
      frame(mode);
      if (extra && f == 2) pulse();
    end
    chk({name, " h_literal"}, h_nom, exp_h);
    chk({name, " s_literal"}, s_nom, 120);
    chk({name, " v_literal"}, v_nom, 180);
    chk({name, " load_count"}, loads - l0, 1);
    chk({name, " load_cycle"}, load_cyc, fall_cyc + 1);
    chk({name, " busy_low_cycle"}, idle_cyc, fall_cyc + 2);
  endtask

  initial begin
    int l0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset h", h_nom, 85);
    chk("reset range", range_out, 50);
    chk("reset busy", busy, 0);
    run("const", 0, 0, 100);
    run("alternate", 1, 0, 100);
    run("ramp", 2, 0, 7);
    run("second_start", 0, 1, 100);
    l0 = loads;
    pulse();
    repeat (3) frame(0);
    @(negedge clk); rst = 1;
    #1;
    chk("midrun_rst h", h_nom, 85);
    chk("midrun_rst s", s_nom, 94);
    chk("midrun_rst v", v_nom, 202);
    chk("midrun_rst range", range_out, 50);
    chk("midrun_rst busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) frame(0);
    chk("midrun_rst no_load", loads - l0, 0);
    run("spread", 3, 0, h_nom_spread());
`ifdef CHROMA_CAL_SPREAD_EN
    chk("spread range_literal", range_out, 28);
`else
    chk("spread range_literal", range_out, 50);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic int h_nom_spread();
    int s = 0;
    for (int dy = 0; dy < 16; dy++)
      for (int dx = 0; dx < 16; dx++) s += 80 + (dx + dy) * 40 / 30;
    return s / 256;
  endfunction
endmodule
